inst_fetch: RTL

Instruction-fetch front end of the MIPS CPU inside `SOC`. It generates the PC and drives the synchronous instruction ROM, which has one-cycle read latency. It registers each returned instruction with its PC into the IF/ID pipeline register consumed by the decode stage. It also handles decode stalls through a one-entry skid buffer, plus branch redirects and flushes.

---
 rtl/inst_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC generation, one-cycle-latency ROM access,
// a one-entry skid buffer for decode stalls, and the IF/ID pipeline register.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_en_i,
    input  logic [31:0] branch_addr_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        f2_valid_q, f2_valid_d;
    logic [31:0] f2_pc_q, f2_pc_d;
    logic        sk_valid_q, sk_valid_d;
    logic [31:0] sk_pc_q, sk_pc_d;
    logic [31:0] sk_inst_q, sk_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;

    logic        issue;
    logic        load_valid;
    logic [31:0] load_pc;
    logic [31:0] load_inst;

    // Redirect targets are always word aligned, so the two low bits are dropped.
    logic unused_branch_lsbs;
    assign unused_branch_lsbs = ^branch_addr_i[1:0];

    assign issue      = (state_q == RUN) && !stall_i;
    assign rom_ce_o   = issue;
    assign rom_addr_o = pc_q;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;

    // Boot/run sequencing: one idle cycle after reset, then fetch forever.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // PC advance and the F2 (read in flight) register; a branch wins over issue.
    always_comb begin
        pc_d       = pc_q;
        f2_valid_d = issue;
        f2_pc_d    = f2_pc_q;
        if (issue) begin
            f2_pc_d = pc_q;
            pc_d    = pc_q + 32'd4;
        end
        if (branch_en_i) begin
            pc_d       = {branch_addr_i[31:2], 2'b00};
            f2_valid_d = 1'b0;
        end
    end

    // Skid capture during stalls and selection of the entry that feeds decode.
    always_comb begin
        sk_valid_d = sk_valid_q;
        sk_pc_d    = sk_pc_q;
        sk_inst_d  = sk_inst_q;
        load_valid = f2_valid_q;
        load_pc    = f2_pc_q;
        load_inst  = f2_valid_q ? rom_data_i : 32'd0;
        if (stall_i) begin
            if (f2_valid_q) begin
                sk_valid_d = 1'b1;
                sk_pc_d    = f2_pc_q;
                sk_inst_d  = rom_data_i;
            end
        end else if (sk_valid_q) begin
            load_valid = 1'b1;
            load_pc    = sk_pc_q;
            load_inst  = sk_inst_q;
            sk_valid_d = 1'b0;
        end
        if (branch_en_i) begin
            sk_valid_d = 1'b0;
        end
    end

    // IF/ID register: flush inserts a bubble, stall freezes, otherwise load.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (flush_i) begin
            id_valid_d = 1'b0;
            id_inst_d  = 32'd0;
        end else if (!stall_i) begin
            id_valid_d = load_valid;
            id_pc_d    = load_pc;
            id_inst_d  = load_inst;
        end
    end

    // All state registers, cleared asynchronously so nothing in flight survives reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            f2_valid_q <= 1'b0;
            f2_pc_q    <= 32'd0;
            sk_valid_q <= 1'b0;
            sk_pc_q    <= 32'd0;
            sk_inst_q  <= 32'd0;
            id_pc_q    <= 32'd0;
            id_inst_q  <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            f2_valid_q <= f2_valid_d;
            f2_pc_q    <= f2_pc_d;
            sk_valid_q <= sk_valid_d;
            sk_pc_q    <= sk_pc_d;
            sk_inst_q  <= sk_inst_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

endmodule
